fastchip_bus: RTL and testbench
===============================

FASTCHIP_BUS -- requirements
Module: fastchip_bus

Interface
REQ-001 SHALL have parameter SLOTS, default 4: number of decoded peripheral slots (1..8).
REQ-002 SHALL have parameter DATA_W, default 16: CPU and slot data width.
REQ-003 SHALL have parameter SLOT_BASE, default {24'hB80000,24'hB80000,24'hDA0000,24'hDE1000}: packed 24-bit base per slot, slot 0 in the LSBs.
REQ-004 SHALL have parameter SLOT_MASK, default {24'hFFFF00,24'hFFF000,24'hFF0000,24'hFFF000}: packed 24-bit compare mask per slot.
REQ-005 SHALL have parameter SLOT_LAT, default {4'd1,4'd0,4'd0,4'd2}: packed 4-bit wait count per slot, where 0 selects handshake mode.
REQ-006 SHALL have parameter TIMEOUT, default 255: handshake cycle limit (1..4095).
REQ-007 SHALL have ports: clk_sys in 1 (sole clock, rising edge); reset_n in 1 (asynchronous, active-low).
REQ-008 SHALL have ports: sel in 1, CPU fast-chip cycle strobe; addr in 24, byte address; rnw in 1, read strobe; uds in 1, upper byte strobe; lds in 1, lower byte strobe; din in DATA_W, write data.
REQ-009 SHALL have ports: sel_ack out 1, legacy chip bypass; ready out 1, cycle complete; dout out DATA_W, read data.
REQ-010 SHALL have ports: slot_sel out SLOTS, one-hot slot select; slot_ready in SLOTS, per-slot completion; slot_dout in SLOTS*DATA_W, packed per-slot read data.
REQ-011 SHALL have ports: bus_err out 1, timeout pulse; err_cnt out 8, timeout count.

Function
REQ-012 SHALL decode a slot hit when (addr & mask) == (base & mask); on overlapping hits the lowest slot index wins.
REQ-013 SHALL drive sel_ack combinationally, high in the same cycle as sel with any hit, and held through the access.
REQ-014 SHALL run FSM IDLE -> WAIT -> DONE -> IDLE.
REQ-015 SHALL, in IDLE, enter WAIT when sel is high with a hit, latching the slot index and clearing the wait counter; with no hit it SHALL stay in IDLE with ready=0.
REQ-016 SHALL assert slot_sel[idx] in WAIT only, starting from the cycle after entry.
REQ-017 SHALL, for a fixed-latency slot (LAT=L>0), enter DONE after L WAIT cycles, latching slot_dout[idx] on that last WAIT cycle; slot_ready SHALL be ignored.
REQ-018 SHALL, for a handshake slot, enter DONE on the first WAIT cycle in which slot_ready[idx] is high, latching slot_dout[idx] on that cycle.
REQ-019 SHALL, in DONE, hold ready=1 and the latched dout, and return to IDLE on the first cycle sel is low.
REQ-020 SHALL, if sel falls while in WAIT, abort to IDLE with no ready and leave err_cnt unchanged.
REQ-021 SHALL register dout and hold it at 0 outside DONE.
REQ-022 SHALL only pass data on reads; on write cycles (rnw=0) the latched dout SHALL be 0.
REQ-023 SHALL not start a new access before IDLE, so back-to-back accesses need sel to drop for at least one cycle.

Reset
REQ-024 SHALL, when reset_n is low, immediately force IDLE, ready=0, dout=0, slot_sel=0, bus_err=0 and err_cnt=0, including mid-access.
REQ-025 SHALL ignore any access that spans reset release until sel drops, with no ready for it.

Configuration
REQ-026 SHALL, with FASTCHIP_TIMEOUT_EN defined, let a handshake slot spend at most TIMEOUT cycles in WAIT without slot_ready; it SHALL then enter DONE with dout all ones, pulse bus_err for one cycle, and increment err_cnt saturating at 255.
REQ-027 SHALL, without FASTCHIP_TIMEOUT_EN, wait indefinitely in WAIT, tie bus_err and err_cnt to 0, and synthesise no timeout counter.

Structure
REQ-028 SHALL place the FSM state enum, the 24-bit address width constant and the all-ones error data constant in shared package fastchip_pkg.
REQ-029 SHALL contain one sub-module, fastchip_decode, a combinational mask-compare and priority encoder giving hit and index.

Verification
REQ-030 SHALL cover: read at 24'hDA0010 (slot 1, handshake), slot_ready high 3 cycles after slot_sel -> ready next cycle, dout = that slot_dout, sel_ack high from cycle 0.
REQ-031 SHALL cover: read at 24'hB80004 (slots 2 and 3 overlap) -> slot 3, LAT=1, loses to slot 2 (LAT=0, handshake) by lowest-index priority -> slot_sel=4'b0100, no fixed-latency completion.
REQ-032 SHALL cover: read at 24'hDE1000 (slot 0, LAT=2) -> ready 3 cycles after sel, slot_ready ignored.
REQ-033 SHALL cover: read at 24'hC00000 (no hit) -> sel_ack=0, ready=0, slot_sel=0 indefinitely.
REQ-034 SHALL cover, with FASTCHIP_TIMEOUT_EN and TIMEOUT=8: handshake slot never ready -> ready after 8 WAIT cycles, dout=16'hFFFF, one bus_err pulse, err_cnt=1; 300 repeats -> err_cnt=255.
REQ-035 SHALL cover: reset_n pulled low during WAIT -> same-cycle slot_sel=0, ready=0, err_cnt=0; sel still high after release -> no ready until sel is toggled.

Source files
------------

// File: rtl/fastchip_pkg.sv
// Shared types and constants for the fast-chip bus decoder and its slot sequencer.
package fastchip_pkg;

  localparam int unsigned ADDR_W = 24;

  // Wide enough for any practical DATA_W; consumers slice the low bits.
  localparam logic [63:0] ERR_DATA = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/fastchip_bus_if.sv
// CPU-side fast-chip cycle signals; master = CPU, slave = fastchip_bus.
interface fastchip_bus_if #(
  parameter int unsigned DATA_W = 16
);
  import fastchip_pkg::*;

  logic              sel;
  logic [ADDR_W-1:0] addr;
  logic              rnw;
  logic              uds;
  logic              lds;
  logic [DATA_W-1:0] din;
  logic              sel_ack;
  logic              ready;
  logic [DATA_W-1:0] dout;

  modport master (
    output sel, addr, rnw, uds, lds, din,
    input  sel_ack, ready, dout
  );

  modport slave (
    input  sel, addr, rnw, uds, lds, din,
    output sel_ack, ready, dout
  );

endinterface

// File: rtl/fastchip_decode.sv
// Combinational mask-compare address decoder; the lowest matching slot index wins.
module fastchip_decode
  import fastchip_pkg::*;
#(
  parameter int unsigned              SLOTS     = 4,
  parameter int unsigned              IDX_W     = 2,
  parameter logic [SLOTS*ADDR_W-1:0]  SLOT_BASE = '0,
  parameter logic [SLOTS*ADDR_W-1:0]  SLOT_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!hit && ((addr & SLOT_MASK[i*ADDR_W +: ADDR_W]) ==
                   (SLOT_BASE[i*ADDR_W +: ADDR_W] & SLOT_MASK[i*ADDR_W +: ADDR_W]))) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fastchip_bus.sv
// Fast-chip bus: decodes CPU cycles onto peripheral slots with fixed-latency or handshake completion.
// Optional handshake timeout with error counting is enabled by defining FASTCHIP_TIMEOUT_EN.
module fastchip_bus
  import fastchip_pkg::*;
#(
  parameter int unsigned             SLOTS     = 4,
  parameter int unsigned             DATA_W    = 16,
  parameter logic [SLOTS*ADDR_W-1:0] SLOT_BASE = {24'hB80000, 24'hB80000, 24'hDA0000, 24'hDE1000},
  parameter logic [SLOTS*ADDR_W-1:0] SLOT_MASK = {24'hFFFF00, 24'hFFF000, 24'hFF0000, 24'hFFF000},
  parameter logic [SLOTS*4-1:0]      SLOT_LAT  = {4'd1, 4'd0, 4'd0, 4'd2},
  parameter int unsigned             TIMEOUT   = 255
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  fastchip_bus_if.slave           cpu,
  output logic [SLOTS-1:0]        slot_sel,
  input  logic [SLOTS-1:0]        slot_ready,
  input  logic [SLOTS*DATA_W-1:0] slot_dout,
  output logic                    bus_err,
  output logic [7:0]              err_cnt
);

  localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
`ifdef FASTCHIP_TIMEOUT_EN
  localparam int unsigned CNT_W = 12;
`else
  localparam int unsigned CNT_W = 4;
`endif

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, hit_idx;
  logic              hit;
  logic [CNT_W-1:0]  cnt_q, cnt_d, lat_last;
  logic [3:0]        lat;
  logic              arm_q, arm_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] dout_q, dout_d, rd_data;
  logic [SLOTS-1:0]  slot_sel_q, slot_sel_d;
  logic              unused_ok;
`ifdef FASTCHIP_TIMEOUT_EN
  logic              bus_err_q, bus_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
`endif

  fastchip_decode #(
    .SLOTS     (SLOTS),
    .IDX_W     (IDX_W),
    .SLOT_BASE (SLOT_BASE),
    .SLOT_MASK (SLOT_MASK)
  ) u_decode (
    .addr (cpu.addr),
    .hit  (hit),
    .idx  (hit_idx)
  );

  assign cpu.sel_ack = cpu.sel & (hit | (state_q != IDLE));
  assign cpu.ready   = ready_q;
  assign cpu.dout    = dout_q;
  assign slot_sel    = slot_sel_q;

  assign lat      = SLOT_LAT[int'(idx_q)*4 +: 4];
  assign lat_last = CNT_W'(lat) - CNT_W'(1);
  assign rd_data  = cpu.rnw ? slot_dout[int'(idx_q)*DATA_W +: DATA_W] : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dout_d  = '0;
    // arm_q stays low after reset until sel has been seen low once, so a
    // cycle straddling reset release is never started.
    arm_d   = arm_q | ~cpu.sel;
`ifdef FASTCHIP_TIMEOUT_EN
    bus_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu.sel && hit && arm_q) begin
          state_d = WAIT;
          idx_d   = hit_idx;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (!cpu.sel) begin
          state_d = IDLE;
        end else if (lat != 4'd0) begin
          if (cnt_q == lat_last) begin
            state_d = DONE;
            dout_d  = rd_data;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (slot_ready[idx_q]) begin
          state_d = DONE;
          dout_d  = rd_data;
        end else begin
`ifdef FASTCHIP_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d   = DONE;
            dout_d    = ERR_DATA[DATA_W-1:0];
            bus_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      DONE: begin
        if (!cpu.sel) state_d = IDLE;
        else          dout_d  = dout_q;
      end
      default: state_d = IDLE;
    endcase

    ready_d    = (state_d == DONE);
    slot_sel_d = '0;
    if (state_d == WAIT) slot_sel_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      arm_q      <= 1'b0;
      ready_q    <= 1'b0;
      dout_q     <= '0;
      slot_sel_q <= '0;
`ifdef FASTCHIP_TIMEOUT_EN
      bus_err_q  <= 1'b0;
      err_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      arm_q      <= arm_d;
      ready_q    <= ready_d;
      dout_q     <= dout_d;
      slot_sel_q <= slot_sel_d;
`ifdef FASTCHIP_TIMEOUT_EN
      bus_err_q  <= bus_err_d;
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

`ifdef FASTCHIP_TIMEOUT_EN
  assign bus_err   = bus_err_q;
  assign err_cnt   = err_cnt_q;
  assign unused_ok = ^{cpu.din, cpu.uds, cpu.lds};
`else
  assign bus_err   = 1'b0;
  assign err_cnt   = '0;
  assign unused_ok = ^{cpu.din, cpu.uds, cpu.lds, TIMEOUT};
`endif

endmodule

// File: tb/tb_fastchip_bus.sv
// Randomized self-checking bench for fastchip_bus against a per-access cycle model.
module tb_fastchip_bus;

  localparam int unsigned SLOTS  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int          TMO    = 8;
  localparam int          INF    = 1 << 30;

  logic                    clk_sys = 1'b0;
  logic                    reset_n = 1'b0;
  logic [SLOTS-1:0]        slot_sel;
  logic [SLOTS-1:0]        slot_ready;
  logic [SLOTS*DATA_W-1:0] slot_dout;
  logic                    bus_err;
  logic [7:0]              err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int m_err = 0;

  logic [23:0] m_base [4] = '{24'hDE1000, 24'hDA0000, 24'hB80000, 24'hB80000};
  logic [23:0] m_mask [4] = '{24'hFFF000, 24'hFF0000, 24'hFFF000, 24'hFFFF00};
  int          m_lat  [4] = '{2, 0, 0, 1};

  fastchip_bus_if #(.DATA_W(DATA_W)) cpu ();

  fastchip_bus #(
    .SLOTS   (SLOTS),
    .DATA_W  (DATA_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .cpu        (cpu),
    .slot_sel   (slot_sel),
    .slot_ready (slot_ready),
    .slot_dout  (slot_dout),
    .bus_err    (bus_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_slot(input logic [23:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    return -1;
  endfunction

  // Drives one CPU cycle from sel rise to sel drop; period p follows clock edge p.
  task automatic run_access(input logic [23:0] a, input logic r, input int hs_k, input int abort_in);
    int s, done_e, abort_at, periods, e;
    logic timed_out, st_wait, st_done;
    logic [DATA_W-1:0] exp_d;
    s         = ref_slot(a);
    timed_out = 1'b0;
    exp_d     = '0;
    abort_at  = abort_in;
    if (s < 0)                 done_e = INF;
    else if (m_lat[s] > 0)     done_e = m_lat[s] + 1;
    else if (hs_k > 0)         done_e = hs_k + 1;
    else                       done_e = INF;
`ifdef FASTCHIP_TIMEOUT_EN
    if (s >= 0 && m_lat[s] == 0 && (hs_k == 0 || hs_k > TMO)) begin
      done_e    = TMO + 1;
      timed_out = 1'b1;
    end
`endif
    if (abort_at >= done_e) abort_at = 0;
    if (abort_at > 0)        periods = abort_at + 2;
    else if (done_e < INF)   periods = done_e + 2;
    else                     periods = 12;

    cpu.addr = a;
    cpu.rnw  = r;
    cpu.uds  = 1'b1;
    cpu.lds  = 1'b1;
    cpu.din  = DATA_W'($urandom);
    for (int p = 0; p < periods; p++) begin
      cpu.sel = !(abort_at > 0 && p >= abort_at);
      for (int i = 0; i < int'(SLOTS); i++) slot_dout[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      slot_ready = SLOTS'($urandom);
      if (s >= 0 && m_lat[s] == 0) slot_ready[s] = (hs_k > 0 && p == hs_k);
      if (p == done_e - 1)
        exp_d = timed_out ? '1 : (r ? slot_dout[s*DATA_W +: DATA_W] : '0);
      #1;
      check_eq("sel_ack", cpu.sel_ack, cpu.sel && s >= 0);
      @(posedge clk_sys); #1;
      e = p + 1;
      st_wait = 1'b0;
      st_done = 1'b0;
      if (!(abort_at > 0 && e > abort_at) && s >= 0) begin
        if (e < done_e) st_wait = 1'b1;
        else            st_done = 1'b1;
      end
      if (timed_out && e == done_e && m_err < 255) m_err++;
      check_eq("slot_sel", slot_sel, st_wait ? (32'd1 << s) : 32'd0);
      check_eq("ready",    cpu.ready, st_done);
      check_eq("dout",     cpu.dout, st_done ? exp_d : '0);
      check_eq("bus_err",  bus_err, timed_out && e == done_e);
      check_eq("err_cnt",  err_cnt, m_err);
    end
    cpu.sel = 1'b0;
    #1;
    check_eq("sel_ack_drop", cpu.sel_ack, 1'b0);
    @(posedge clk_sys); #1;
    check_eq("ready_drop",    cpu.ready, 1'b0);
    check_eq("dout_drop",     cpu.dout, '0);
    check_eq("slot_sel_drop", slot_sel, '0);
  endtask

  initial begin
    logic [23:0] a;
    int          t;
    cpu.sel    = 1'b0;
    cpu.addr   = '0;
    cpu.rnw    = 1'b1;
    cpu.uds    = 1'b0;
    cpu.lds    = 1'b0;
    cpu.din    = '0;
    slot_ready = '0;
    slot_dout  = '0;

    repeat (2) @(posedge clk_sys);
    #1;
    check_eq("rst_ready",    cpu.ready, 1'b0);
    check_eq("rst_dout",     cpu.dout, '0);
    check_eq("rst_slot_sel", slot_sel, '0);
    check_eq("rst_bus_err",  bus_err, 1'b0);
    check_eq("rst_err_cnt",  err_cnt, '0);
    reset_n = 1'b1;
    repeat (2) begin @(posedge clk_sys); #1; end

    run_access(24'hDA0010, 1'b1, 4, 0);   // handshake, ready 3 cycles after slot_sel
    run_access(24'hB80004, 1'b1, 2, 0);   // overlap: slot 2 handshake beats slot 3
    run_access(24'hDE1000, 1'b1, 0, 0);   // fixed latency 2, slot_ready noise
    run_access(24'hC00000, 1'b1, 1, 0);   // no hit
    run_access(24'hDA0010, 1'b0, 2, 0);   // write returns 0
    run_access(24'hDA0010, 1'b1, 0, 3);   // abort in WAIT

    for (int n = 0; n < 60; n++) begin
      t = $urandom_range(0, 4);
      if (t < 4) a = (m_base[t] & m_mask[t]) | (24'($urandom) & ~m_mask[t]);
      else       a = 24'($urandom);
      run_access(a, $urandom_range(0, 3) != 0, $urandom_range(1, 6),
                 ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
    end

    for (int n = 0; n < 300; n++) run_access(24'hDA0020, 1'b1, 0, 0);
    check_eq("err_cnt_final", err_cnt, m_err);

    // Reset mid-WAIT, then an access that straddles release must be ignored.
    cpu.addr   = 24'hDA0010;
    cpu.rnw    = 1'b1;
    cpu.sel    = 1'b1;
    slot_ready = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("pre_rst_slot_sel", slot_sel, 4'b0010);
    #2 reset_n = 1'b0;
    #1;
    m_err = 0;
    check_eq("mid_rst_slot_sel", slot_sel, '0);
    check_eq("mid_rst_ready",    cpu.ready, 1'b0);
    check_eq("mid_rst_err_cnt",  err_cnt, m_err);
    check_eq("mid_rst_dout",     cpu.dout, '0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      slot_ready = '1;
      @(posedge clk_sys); #1;
      check_eq("post_rst_ready",    cpu.ready, 1'b0);
      check_eq("post_rst_slot_sel", slot_sel, '0);
    end
    cpu.sel = 1'b0;
    @(posedge clk_sys); #1;
    run_access(24'hDA0010, 1'b1, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
